uncache_unit: RTL and testbench

Parametrised uncached-access unit between the CPU memory stage and the AXI bridge, for MMIO and other uncached loads and stores. Stores post into a WBUF_DEPTH-entry write buffer and retire to the bridge in the background, so the pipeline does not stall on them. Loads stall the pipeline until the buffer has drained and the bridge returns data. The bridge handshake is unchanged: en/accept/fin.

---
 rtl/uncache_pkg.sv | 21 ++
 rtl/uncache_if.sv | 32 +++
 rtl/uncache_wbuf.sv | 38 +++
 rtl/uncache_unit.sv | 175 +++++++++++++++++
 tb/tb_uncache_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uncache_pkg.sv
// Shared types for the uncached-access unit: FSM/kind encodings and write-entry sizing.
package uncache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b11,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_e;

  // Packed write entry is {addr, wsel, wdata}; the struct itself lives where the widths are known.
  function automatic int wentry_w(input int addr_w, input int data_w);
    return addr_w + data_w / 8 + data_w;
  endfunction

endpackage

// File: rtl/uncache_if.sv
// CPU-side and bridge-side bundles of the uncached-access unit.
interface uncache_cpu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  en;
  logic [DATA_W/8-1:0]   wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  stallreq;
  logic                  wbuf_empty;

  modport master (output en, wen, addr, wdata, input rdata, stallreq, wbuf_empty);
  modport slave  (input en, wen, addr, wdata, output rdata, stallreq, wbuf_empty);
endinterface

interface uncache_axi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  axi_en;
  logic                  accept;
  logic [DATA_W/8-1:0]   axi_wsel;
  logic [ADDR_W-1:0]     axi_addr;
  logic [DATA_W-1:0]     axi_wdata;
  logic [DATA_W-1:0]     axi_rdata;
  logic                  fin;

  modport master (output axi_en, axi_wsel, axi_addr, axi_wdata, input accept, axi_rdata, fin);
  modport slave  (input axi_en, axi_wsel, axi_addr, axi_wdata, output accept, axi_rdata, fin);
endinterface

// File: rtl/uncache_wbuf.sv
// Posted-store FIFO: DEPTH entries, pointers carry one extra wrap bit to tell full from empty.
module uncache_wbuf #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uncache_unit.sv
// Uncached load/store unit between the memory stage and the AXI bridge (en/accept/fin).
// UNCACHE_WBUF_EN: post stores into a write buffer; otherwise stores stall like loads.
module uncache_unit
  import uncache_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uncache_cpu_if.slave  cpu,
  uncache_axi_if.master axi
);
  localparam int WSEL_W = DATA_W / 8;

  if (DATA_W % 8 != 0 || WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uncache_unit: DATA_W must be a byte multiple, WBUF_DEPTH a power of two >= 2");
  end

  state_e              state, state_n;
  kind_e               kind, kind_n;
  logic                rd_done, rd_done_n;
  logic                axi_en_q, axi_en_n;
  logic [WSEL_W-1:0]   axi_wsel_q, axi_wsel_n;
  logic [ADDR_W-1:0]   axi_addr_q, axi_addr_n;
  logic [DATA_W-1:0]   axi_wdata_q, axi_wdata_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                is_store;

  assign is_store = cpu.en & (|cpu.wen);

`ifdef UNCACHE_WBUF_EN
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WSEL_W-1:0] wsel;
    logic [DATA_W-1:0] wdata;
  } wentry_t;

  wentry_t push_ent, head_ent;
  logic    is_load, push, pop, full, empty;

  assign is_load  = cpu.en & ~(|cpu.wen);
  assign push_ent = '{addr: cpu.addr, wsel: cpu.wen, wdata: cpu.wdata};
  // full is the registered occupancy, so a same-cycle pop never makes room for this push
  assign push     = is_store & ~full;

  uncache_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .W     (wentry_w(ADDR_W, DATA_W))
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_ent),
    .head  (head_ent),
    .full  (full),
    .empty (empty)
  );

  assign cpu.stallreq   = (is_load & ~rd_done) | (is_store & full);
  assign cpu.wbuf_empty = empty & (state == ST_IDLE);
`else
  assign cpu.stallreq   = cpu.en & ~rd_done;
  assign cpu.wbuf_empty = (state == ST_IDLE);
`endif

  always_comb begin
    state_n     = state;
    kind_n      = kind;
    rd_done_n   = rd_done;
    axi_en_n    = axi_en_q;
    axi_wsel_n  = axi_wsel_q;
    axi_addr_n  = axi_addr_q;
    axi_wdata_n = axi_wdata_q;
    rdata_n     = rdata_q;
`ifdef UNCACHE_WBUF_EN
    pop         = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
`ifdef UNCACHE_WBUF_EN
        // Drain first: a load only issues once every earlier store has left the buffer.
        if (!empty) begin
          pop         = 1'b1;
          axi_en_n    = 1'b1;
          axi_addr_n  = head_ent.addr;
          axi_wsel_n  = head_ent.wsel;
          axi_wdata_n = head_ent.wdata;
          kind_n      = KIND_WRITE;
          state_n     = ST_REQ;
        end else if (is_load && !rd_done) begin
          axi_en_n    = 1'b1;
          axi_addr_n  = cpu.addr;
          axi_wsel_n  = '0;
          axi_wdata_n = '0;
          kind_n      = KIND_READ;
          state_n     = ST_REQ;
        end
`else
        if (cpu.en && !rd_done) begin
          axi_en_n    = 1'b1;
          axi_addr_n  = cpu.addr;
          axi_wsel_n  = cpu.wen;
          axi_wdata_n = cpu.wdata;
          kind_n      = is_store ? KIND_WRITE : KIND_READ;
          state_n     = ST_REQ;
        end
`endif
      end
      ST_REQ: begin
        if (axi.accept) begin
          axi_en_n    = 1'b0;
          axi_addr_n  = '0;
          axi_wsel_n  = '0;
          axi_wdata_n = '0;
          state_n     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (axi.fin) begin
`ifdef UNCACHE_WBUF_EN
          if (kind == KIND_WRITE) begin
            state_n = ST_IDLE;
          end else begin
            rdata_n   = axi.axi_rdata;
            rd_done_n = 1'b1;
            state_n   = ST_DONE;
          end
`else
          // Unbuffered stores also pass through DONE so the stall drops for one cycle.
          if (kind == KIND_READ) rdata_n = axi.axi_rdata;
          rd_done_n = 1'b1;
          state_n   = ST_DONE;
`endif
        end
      end
      ST_DONE: begin
        rd_done_n = 1'b0;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      kind        <= KIND_READ;
      rd_done     <= 1'b0;
      axi_en_q    <= 1'b0;
      axi_wsel_q  <= '0;
      axi_addr_q  <= '0;
      axi_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state       <= state_n;
      kind        <= kind_n;
      rd_done     <= rd_done_n;
      axi_en_q    <= axi_en_n;
      axi_wsel_q  <= axi_wsel_n;
      axi_addr_q  <= axi_addr_n;
      axi_wdata_q <= axi_wdata_n;
      rdata_q     <= rdata_n;
    end
  end

  assign axi.axi_en    = axi_en_q;
  assign axi.axi_wsel  = axi_wsel_q;
  assign axi.axi_addr  = axi_addr_q;
  assign axi.axi_wdata = axi_wdata_q;
  assign cpu.rdata     = rdata_q;

endmodule

// File: tb/tb_uncache_unit.sv
// Directed bench for uncache_unit; expectations follow whichever UNCACHE_WBUF_EN build is compiled.
module tb_uncache_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uncache_cpu_if #(.DATA_W(32), .ADDR_W(32)) cpu ();
  uncache_axi_if #(.DATA_W(32), .ADDR_W(32)) axi ();

  uncache_unit #(.DATA_W(32), .ADDR_W(32), .WBUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .axi (axi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    cpu.en    = e;
    cpu.wen   = w;
    cpu.addr  = a;
    cpu.wdata = d;
  endtask

  // Bridge responder: wait for axi_en, accept that cycle, fin the next; returns in the cycle after fin.
  task automatic serve(input logic [31:0] rd, output logic [31:0] a, output logic [3:0] ws, output logic [31:0] wd);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 40) begin
      if (axi.axi_en === 1'b1) seen = 1'b1;
      else begin tick(); settle(); n++; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL serve_timeout axi_en got %b exp 1", axi.axi_en); end
    a  = axi.axi_addr;
    ws = axi.axi_wsel;
    wd = axi.axi_wdata;
    axi.accept = 1'b1;
    tick(); axi.accept = 1'b0; axi.fin = 1'b1; axi.axi_rdata = rd;
    tick(); axi.fin = 1'b0; axi.axi_rdata = '0; settle();
  endtask

  task automatic test_reset();
    rst = 1'b0; drive(1'b0, 4'h0, 32'h0, 32'h0);
    axi.accept = 1'b0; axi.fin = 1'b0; axi.axi_rdata = '0;
    #3;
    checks++; if (axi.axi_en !== 1'b0)       begin errors++; $display("FAIL rst_axi_en got %b exp 0", axi.axi_en); end
    checks++; if (axi.axi_addr !== 32'h0)    begin errors++; $display("FAIL rst_axi_addr got %h exp 0", axi.axi_addr); end
    checks++; if (axi.axi_wsel !== 4'h0)     begin errors++; $display("FAIL rst_axi_wsel got %h exp 0", axi.axi_wsel); end
    checks++; if (axi.axi_wdata !== 32'h0)   begin errors++; $display("FAIL rst_axi_wdata got %h exp 0", axi.axi_wdata); end
    checks++; if (cpu.rdata !== 32'h0)       begin errors++; $display("FAIL rst_rdata got %h exp 0", cpu.rdata); end
    checks++; if (cpu.stallreq !== 1'b0)     begin errors++; $display("FAIL rst_stallreq got %b exp 0", cpu.stallreq); end
    tick(); tick(); rst = 1'b1; tick(); settle();
    checks++; if (cpu.wbuf_empty !== 1'b1)   begin errors++; $display("FAIL rst_wbuf_empty got %b exp 1", cpu.wbuf_empty); end
  endtask

  task automatic test_single_load();
    drive(1'b1, 4'h0, 32'hBFAF_8000, 32'h0); settle();                          // t
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL ld_stall_t got %b exp 1", cpu.stallreq); end
    checks++; if (axi.axi_en !== 1'b0)   begin errors++; $display("FAIL ld_axi_en_t got %b exp 0", axi.axi_en); end
    tick(); axi.accept = 1'b1; settle();                                        // t+1
    checks++; if (axi.axi_en !== 1'b1)          begin errors++; $display("FAIL ld_axi_en_t1 got %b exp 1", axi.axi_en); end
    checks++; if (axi.axi_addr !== 32'hBFAF_8000) begin errors++; $display("FAIL ld_axi_addr got %h exp bfaf8000", axi.axi_addr); end
    checks++; if (axi.axi_wsel !== 4'h0)        begin errors++; $display("FAIL ld_axi_wsel got %h exp 0", axi.axi_wsel); end
    tick(); axi.accept = 1'b0; settle();                                        // t+2
    checks++; if (axi.axi_en !== 1'b0)   begin errors++; $display("FAIL ld_axi_en_t2 got %b exp 0", axi.axi_en); end
    checks++; if (axi.axi_addr !== 32'h0) begin errors++; $display("FAIL ld_axi_addr_clr got %h exp 0", axi.axi_addr); end
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL ld_stall_t2 got %b exp 1", cpu.stallreq); end
    tick(); axi.fin = 1'b1; axi.axi_rdata = 32'h1234_5678; settle();            // t+3
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL ld_stall_t3 got %b exp 1", cpu.stallreq); end
    tick(); axi.fin = 1'b0; axi.axi_rdata = '0; settle();                       // t+4
    checks++; if (cpu.rdata !== 32'h1234_5678) begin errors++; $display("FAIL ld_rdata got %h exp 12345678", cpu.rdata); end
    checks++; if (cpu.stallreq !== 1'b0)       begin errors++; $display("FAIL ld_stall_t4 got %b exp 0", cpu.stallreq); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();                          // t+5
    tick(); settle();                                                           // t+6
    checks++; if (axi.axi_en !== 1'b0)         begin errors++; $display("FAIL ld_no_reissue got %b exp 0", axi.axi_en); end
    checks++; if (cpu.rdata !== 32'h1234_5678) begin errors++; $display("FAIL ld_rdata_hold got %h exp 12345678", cpu.rdata); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h0, 32'h1000_0010, 32'h0); settle();                          // t
    tick(); axi.accept = 1'b1; settle();                                        // t+1
    checks++; if (axi.axi_en !== 1'b1) begin errors++; $display("FAIL b2b_en1 got %b exp 1", axi.axi_en); end
    tick(); axi.accept = 1'b0; axi.fin = 1'b1; axi.axi_rdata = 32'hCAFE_0001; settle(); // t+2
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL b2b_stall_t2 got %b exp 1", cpu.stallreq); end
    tick(); axi.fin = 1'b0; axi.axi_rdata = '0; settle();                       // t+3
    checks++; if (cpu.stallreq !== 1'b0)       begin errors++; $display("FAIL b2b_minlat_stall got %b exp 0", cpu.stallreq); end
    checks++; if (cpu.rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_rdata1 got %h exp cafe0001", cpu.rdata); end
    tick(); drive(1'b1, 4'h0, 32'h1000_0014, 32'h0); settle();                  // t+4
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %b exp 1", cpu.stallreq); end
    checks++; if (axi.axi_en !== 1'b0)   begin errors++; $display("FAIL b2b_en_gap got %b exp 0", axi.axi_en); end
    tick(); axi.accept = 1'b1; settle();                                        // t+5
    checks++; if (axi.axi_en !== 1'b1)            begin errors++; $display("FAIL b2b_en2 got %b exp 1", axi.axi_en); end
    checks++; if (axi.axi_addr !== 32'h1000_0014) begin errors++; $display("FAIL b2b_addr2 got %h exp 10000014", axi.axi_addr); end
    tick(); axi.accept = 1'b0; axi.fin = 1'b1; axi.axi_rdata = 32'hCAFE_0002; settle(); // t+6
    tick(); axi.fin = 1'b0; axi.axi_rdata = '0; settle();                       // t+7
    checks++; if (cpu.rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL b2b_rdata2 got %h exp cafe0002", cpu.rdata); end
    checks++; if (cpu.stallreq !== 1'b0)       begin errors++; $display("FAIL b2b_stall_end got %b exp 0", cpu.stallreq); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();
  endtask

`ifdef UNCACHE_WBUF_EN
  task automatic test_store_single();
    drive(1'b1, 4'hF, 32'hBFD0_0100, 32'h0BAD_F00D); settle();                  // t: push
    checks++; if (cpu.stallreq !== 1'b0) begin errors++; $display("FAIL st_stall got %b exp 0", cpu.stallreq); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();                          // t+1: pop
    checks++; if (cpu.wbuf_empty !== 1'b0) begin errors++; $display("FAIL st_wbuf_empty_t1 got %b exp 0", cpu.wbuf_empty); end
    tick(); axi.accept = 1'b1; settle();                                        // t+2: REQ
    checks++; if (axi.axi_en !== 1'b1)            begin errors++; $display("FAIL st_axi_en got %b exp 1", axi.axi_en); end
    checks++; if (axi.axi_addr !== 32'hBFD0_0100) begin errors++; $display("FAIL st_axi_addr got %h exp bfd00100", axi.axi_addr); end
    checks++; if (axi.axi_wsel !== 4'hF)          begin errors++; $display("FAIL st_axi_wsel got %h exp f", axi.axi_wsel); end
    checks++; if (axi.axi_wdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL st_axi_wdata got %h exp 0badf00d", axi.axi_wdata); end
    tick(); axi.accept = 1'b0; axi.fin = 1'b1; settle();                        // t+3: WAIT
    tick(); axi.fin = 1'b0; settle();                                           // t+4: IDLE
    checks++; if (cpu.wbuf_empty !== 1'b1)     begin errors++; $display("FAIL st_wbuf_empty_end got %b exp 1", cpu.wbuf_empty); end
    checks++; if (cpu.rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL st_rdata_hold got %h exp cafe0002", cpu.rdata); end
  endtask

  // One store holds the bridge (accept low), then 5 more stores: 4 push freely, the 5th waits for a pop.
  task automatic test_wbuf_full();
    logic [31:0] a, wd;
    logic [3:0]  ws;
    for (int i = 0; i < 5; i++) begin                                           // c0..c4
      drive(1'b1, 4'hF, 32'h2000_0000 + 32'(4 * i), 32'h0000_00D0 + 32'(i)); settle();
      checks++; if (cpu.stallreq !== 1'b0) begin errors++; $display("FAIL full_push%0d stall got %b exp 0", i, cpu.stallreq); end
      tick();
    end
    drive(1'b1, 4'hF, 32'h2000_0014, 32'h0000_00D5); settle();                  // c5
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL full_stall_c5 got %b exp 1", cpu.stallreq); end
    tick(); axi.accept = 1'b1; settle();                                        // c6
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL full_stall_c6 got %b exp 1", cpu.stallreq); end
    tick(); axi.accept = 1'b0; axi.fin = 1'b1; settle();                        // c7
    tick(); axi.fin = 1'b0; settle();                                           // c8: pop, no bypass
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL full_no_bypass got %b exp 1", cpu.stallreq); end
    tick(); settle();                                                           // c9: push
    checks++; if (cpu.stallreq !== 1'b0)          begin errors++; $display("FAIL full_push_late got %b exp 0", cpu.stallreq); end
    checks++; if (axi.axi_addr !== 32'h2000_0004) begin errors++; $display("FAIL full_head_addr got %h exp 20000004", axi.axi_addr); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();
    for (int i = 1; i < 6; i++) begin
      serve(32'h0, a, ws, wd);
      checks++; if (a !== 32'h2000_0000 + 32'(4 * i))  begin errors++; $display("FAIL drain%0d addr got %h exp %h", i, a, 32'h2000_0000 + 32'(4 * i)); end
      checks++; if (wd !== 32'h0000_00D0 + 32'(i))     begin errors++; $display("FAIL drain%0d wdata got %h exp %h", i, wd, 32'h0000_00D0 + 32'(i)); end
    end
    checks++; if (cpu.wbuf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", cpu.wbuf_empty); end
  endtask

  task automatic test_store_then_load();
    logic [31:0] a, wd;
    logic [3:0]  ws;
    drive(1'b1, 4'b0001, 32'hBFD0_0200, 32'h0000_00AA); settle();               // t
    checks++; if (cpu.stallreq !== 1'b0) begin errors++; $display("FAIL sl_store_stall got %b exp 0", cpu.stallreq); end
    tick(); drive(1'b1, 4'h0, 32'hBFD0_0200, 32'h0); settle();                  // t+1
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL sl_load_stall got %b exp 1", cpu.stallreq); end
    serve(32'hFFFF_FFFF, a, ws, wd);
    checks++; if (ws !== 4'b0001)        begin errors++; $display("FAIL sl_first_wsel got %h exp 1", ws); end
    checks++; if (wd !== 32'h0000_00AA)  begin errors++; $display("FAIL sl_first_wdata got %h exp aa", wd); end
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL sl_stall_after_wr got %b exp 1", cpu.stallreq); end
    checks++; if (cpu.rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL sl_wr_no_rdata got %h exp cafe0002", cpu.rdata); end
    serve(32'h5566_7788, a, ws, wd);
    checks++; if (ws !== 4'h0)           begin errors++; $display("FAIL sl_second_wsel got %h exp 0", ws); end
    checks++; if (a !== 32'hBFD0_0200)   begin errors++; $display("FAIL sl_second_addr got %h exp bfd00200", a); end
    checks++; if (cpu.stallreq !== 1'b0) begin errors++; $display("FAIL sl_stall_end got %b exp 0", cpu.stallreq); end
    checks++; if (cpu.rdata !== 32'h5566_7788) begin errors++; $display("FAIL sl_rdata got %h exp 55667788", cpu.rdata); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin                                           // c0..c3
      drive(1'b1, 4'hF, 32'h3000_0000 + 32'(4 * i), 32'h0000_00E0 + 32'(i));
      tick();
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0); axi.accept = 1'b1; settle();               // c4: REQ accepted
    tick(); axi.accept = 1'b0; settle();                                        // c5: WAIT, 3 buffered
    checks++; if (cpu.wbuf_empty !== 1'b0) begin errors++; $display("FAIL rm_pre_empty got %b exp 0", cpu.wbuf_empty); end
    rst = 1'b0; #1;
    checks++; if (cpu.rdata !== 32'h0)     begin errors++; $display("FAIL rm_rdata got %h exp 0", cpu.rdata); end
    checks++; if (axi.axi_en !== 1'b0)     begin errors++; $display("FAIL rm_axi_en got %b exp 0", axi.axi_en); end
    checks++; if (cpu.wbuf_empty !== 1'b1) begin errors++; $display("FAIL rm_empty got %b exp 1", cpu.wbuf_empty); end
    tick(); tick(); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
      checks++; if (axi.axi_en !== 1'b0) begin errors++; $display("FAIL rm_no_axi_en%0d got %b exp 0", i, axi.axi_en); end
    end
    checks++; if (cpu.wbuf_empty !== 1'b1) begin errors++; $display("FAIL rm_post_empty got %b exp 1", cpu.wbuf_empty); end
  endtask
`else
  task automatic test_store_nobuf();
    drive(1'b1, 4'hF, 32'hBFD0_0300, 32'h1111_2222); settle();                  // t
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL nb_stall_t got %b exp 1", cpu.stallreq); end
    tick(); axi.accept = 1'b1; settle();                                        // t+1
    checks++; if (axi.axi_en !== 1'b1)             begin errors++; $display("FAIL nb_axi_en got %b exp 1", axi.axi_en); end
    checks++; if (axi.axi_wsel !== 4'hF)           begin errors++; $display("FAIL nb_axi_wsel got %h exp f", axi.axi_wsel); end
    checks++; if (axi.axi_wdata !== 32'h1111_2222) begin errors++; $display("FAIL nb_axi_wdata got %h exp 11112222", axi.axi_wdata); end
    tick(); axi.accept = 1'b0; settle();                                        // t+2
    for (int i = 2; i < 5; i++) begin                                           // t+2..t+4
      checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL nb_stall_t%0d got %b exp 1", i, cpu.stallreq); end
      tick(); settle();
    end
    axi.fin = 1'b1; axi.axi_rdata = 32'hDEAD_BEEF; settle();                    // t+5: fin
    checks++; if (cpu.stallreq !== 1'b1) begin errors++; $display("FAIL nb_stall_fin got %b exp 1", cpu.stallreq); end
    tick(); axi.fin = 1'b0; axi.axi_rdata = '0; settle();                       // t+6: DONE
    checks++; if (cpu.stallreq !== 1'b0)       begin errors++; $display("FAIL nb_stall_release got %b exp 0", cpu.stallreq); end
    checks++; if (cpu.rdata !== 32'hCAFE_0002) begin errors++; $display("FAIL nb_rdata_hold got %h exp cafe0002", cpu.rdata); end
    checks++; if (cpu.wbuf_empty !== 1'b0)     begin errors++; $display("FAIL nb_empty_done got %b exp 0", cpu.wbuf_empty); end
    tick(); drive(1'b0, 4'h0, 32'h0, 32'h0); settle();                          // t+7: IDLE
    checks++; if (cpu.wbuf_empty !== 1'b1) begin errors++; $display("FAIL nb_empty_idle got %b exp 1", cpu.wbuf_empty); end
    checks++; if (axi.axi_en !== 1'b0)     begin errors++; $display("FAIL nb_axi_en_idle got %b exp 0", axi.axi_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_load();
    test_back_to_back();
`ifdef UNCACHE_WBUF_EN
    test_store_single();
    test_wbuf_full();
    test_store_then_load();
    test_reset_mid();
`else
    test_store_nobuf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
